fft_stage_ctrl: RTL
===================

# fft_stage_ctrl

Control and address generator for the in-place radix-2 DIT burst FFT/IFFT engine. It sits directly upstream of the butterfly datapath. For every stage it issues one butterfly per cycle: ping-pong RAM read addresses for the A/B operand pair and the twiddle ROM address. It also drives the butterfly side-band inputs (`mult_en`, `fft_i_index`, `first_lev_s`) delayed to match RAM read latency. Between stages it counts the butterfly's `dat_out_vld` returns, so the next stage never reads a location that has not been written back.

## Interface
Parameters:
- `LOG2N`, 10, log2 of transform length N (2..16); N/2 butterflies per stage, LOG2N stages.
- `RAM_LAT`, 1, cycles from `rd_en` to read data valid at the butterfly inputs (1..4).

Ports:
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to run a full transform; ignored while `busy`=1.
- `wr_vld`  in  1  butterfly `dat_out_vld`; one pulse per completed butterfly write-back.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last write-back of the final stage.
- `stage`  out  LOG2N  current stage s (0..LOG2N-1).
- `rd_en`  out  1  RAM read strobe for one butterfly pair.
- `rd_addr_a`  out  LOG2N  A operand address.
- `rd_addr_b`  out  LOG2N  B operand address.
- `tw_addr`  out  LOG2N-1  twiddle ROM index.
- `mult_en`  out  1  `rd_en` delayed RAM_LAT cycles; drives butterfly `mult_en`.
- `fft_i_index`  out  LOG2N  `rd_addr_a` delayed RAM_LAT cycles; write-back base address.
- `first_lev_s`  out  1  (s==0) delayed RAM_LAT cycles.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - `start`=1 → ISSUE, with s=0, k=0, wcnt=0.
- ISSUE (`rd_en`=1 every cycle):
  - Outputs for butterfly k: h=2^s, grp=k>>s, pos=k&(h-1).
  - `rd_addr_a` = (grp<<(s+1)) | pos.
  - `rd_addr_b` = `rd_addr_a` + h.
  - `tw_addr` = pos<<(LOG2N-1-s).
  - k increments each cycle. At k=N/2-1 → DRAIN, with k cleared.
- DRAIN:
  - `rd_en`=0.
  - Wait until wcnt==N/2, then either advance (s<LOG2N-1: s+1, wcnt=0 → ISSUE) or finish (s=LOG2N-1: `done`=1 → IDLE).
  - The wcnt==N/2 test includes a `wr_vld` arriving in that same cycle.
- wcnt:
  - Increments on `wr_vld` in ISSUE and DRAIN; saturates at N/2.
  - `wr_vld` in IDLE is ignored.
- Delay line: `mult_en`, `fft_i_index`, `first_lev_s` come from a RAM_LAT-deep shift register fed by `rd_en`, `rd_addr_a`, (s==0).
  - The delay line keeps shifting in every state, so the tail of the final stage still drains after `done`.
- All address arithmetic is unsigned, modulo 2^LOG2N; no overflow is possible by construction.
- `start` while `busy` is dropped with no side effect.
- Reset: `rst`=1 at any time, including mid-transform, returns IDLE next edge.
  - All outputs and counters go to 0: `busy`, `done`, `stage`, `rd_en`, addresses, `tw_addr`, `mult_en`, `fft_i_index`, `first_lev_s`.
  - The delay line is flushed.

## Timing
- Cycle 0: `start` sampled. Cycles 1..N/2: `rd_en`=1 for stage 0, with `busy`=1 from cycle 1.
- `mult_en` is high on cycles 1+RAM_LAT .. N/2+RAM_LAT.
- Next stage's first `rd_en` is the cycle after wcnt reaches N/2. The gap depends only on returned `wr_vld`, not on a fixed butterfly latency.
- `done` is asserted the cycle after the final wcnt==N/2 condition. `busy` falls in the same cycle `done` pulses.
- Total with butterfly latency D (rd_en→wr_vld = RAM_LAT+D): LOG2N·(N/2 + RAM_LAT + D) + 1 cycles from `start` to `done`.

## Test plan
- LOG2N=3, RAM_LAT=1, model returns `wr_vld` 2 cycles after `mult_en` → expected (a,b,tw) sequence:
  - stage 0: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
  - stage 1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
  - stage 2: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
  - `done` at cycle 3·(4+1+2)+1=22.
- `mult_en`/`fft_i_index`/`first_lev_s` alignment, for RAM_LAT=1 and RAM_LAT=3:
  - each equals `rd_en`/`rd_addr_a`/(s==0) shifted exactly RAM_LAT cycles;
  - `first_lev_s`=1 only for the 4 stage-0 butterflies.
- Withhold the last `wr_vld` of stage 1 for 20 cycles → `rd_en` stays 0 and `stage`=1 throughout; stage 2 issues the cycle after that pulse arrives.
- Pulse `start` at cycles 5 and 10 of a run → no restart; exactly one `done` per accepted `start`; extra `wr_vld` in IDLE → no state change.
- Assert `rst` during stage 1 ISSUE → next cycle all outputs 0 and no `mult_en` in flight; a new `start` then reproduces the first scenario's sequence exactly.
- LOG2N=10 full run with randomized `wr_vld` delay 1..5 → 10 stages of 512 `rd_en`, every (a,b) pair unique per stage, b-a=2^s, one `done`.

Source files
------------

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT: issues A/B/twiddle
// addresses one butterfly per cycle and holds each stage until all write-backs return.
module fft_stage_ctrl #(
    parameter int LOG2N   = 10,
    parameter int RAM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wr_vld,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             mult_en,
    output logic [LOG2N-1:0] fft_i_index,
    output logic             first_lev_s
);
    localparam logic [LOG2N-1:0] HALF   = LOG2N'(1) << (LOG2N - 1);
    localparam logic [LOG2N-2:0] K_LAST = '1;
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] s_q, s_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic             done_q, done_d;

    logic [RAM_LAT-1:0]            dly_en_q, dly_en_d;
    logic [RAM_LAT-1:0]            dly_fl_q, dly_fl_d;
    logic [RAM_LAT-1:0][LOG2N-1:0] dly_addr_q, dly_addr_d;

    logic [LOG2N-1:0] k_ext, h, pos, grp, addr_a;
    logic [LOG2N-1:0] wcnt_nxt;
    logic             drained;

    // Butterfly k of stage s: group k>>s, offset k&(h-1), pair spacing h=2^s.
    always_comb begin
        k_ext  = LOG2N'(k_q);
        h      = LOG2N'(1) << s_q;
        pos    = k_ext & (h - LOG2N'(1));
        grp    = k_ext >> s_q;
        addr_a = (grp << (s_q + LOG2N'(1))) | pos;
    end

    assign rd_en     = (state_q == ISSUE);
    assign rd_addr_a = rd_en ? addr_a : '0;
    assign rd_addr_b = rd_en ? (addr_a + h) : '0;
    assign tw_addr   = rd_en ? (LOG2N-1)'(pos << (S_LAST - s_q)) : '0;

    // A write-back arriving in the drain-check cycle counts toward completion.
    always_comb begin
        wcnt_nxt = wcnt_q;
        if (wr_vld && wcnt_q != HALF) wcnt_nxt = wcnt_q + LOG2N'(1);
        drained = (wcnt_nxt == HALF);
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        wcnt_d  = wcnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    s_d     = '0;
                    k_d     = '0;
                    wcnt_d  = '0;
                end
            end
            ISSUE: begin
                wcnt_d = wcnt_nxt;
                k_d    = k_q + (LOG2N-1)'(1);
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end
            end
            DRAIN: begin
                wcnt_d = wcnt_nxt;
                if (drained) begin
                    wcnt_d = '0;
                    if (s_q == S_LAST) begin
                        state_d = IDLE;
                        s_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        s_d     = s_q + LOG2N'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Side-band delay line runs in every state so the last stage's tail drains after done.
    always_comb begin
        dly_en_d      = '0;
        dly_fl_d      = '0;
        dly_addr_d    = '0;
        dly_en_d[0]   = rd_en;
        dly_fl_d[0]   = rd_en && (s_q == '0);
        dly_addr_d[0] = rd_addr_a;
        for (int i = 1; i < RAM_LAT; i++) begin
            dly_en_d[i]   = dly_en_q[i-1];
            dly_fl_d[i]   = dly_fl_q[i-1];
            dly_addr_d[i] = dly_addr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            k_q        <= '0;
            wcnt_q     <= '0;
            done_q     <= 1'b0;
            dly_en_q   <= '0;
            dly_fl_q   <= '0;
            dly_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            k_q        <= k_d;
            wcnt_q     <= wcnt_d;
            done_q     <= done_d;
            dly_en_q   <= dly_en_d;
            dly_fl_q   <= dly_fl_d;
            dly_addr_q <= dly_addr_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign stage       = s_q;
    assign mult_en     = dly_en_q[RAM_LAT-1];
    assign fft_i_index = dly_addr_q[RAM_LAT-1];
    assign first_lev_s = dly_fl_q[RAM_LAT-1];
endmodule
